// File: rtl/dense_dot25_calc_pkg.sv
// -----------------------------------------------------------------------------
// dense_dot25_calc_pkg
// Shared definitions for the dense layer calc interface. The dense layer
// controller imports the same package, so the bus layout and Q8.8 limits live
// in one place.
//   Q_WIDTH / Q_FRAC / Q_N_TAP : word width, fractional bits, vector length
//   Q_SAT_MAX / Q_SAT_MIN      : Q8.8 saturation limits
//   VEC_A_BASE / VEC_B_BASE /
//   BIAS_BASE                  : bit offsets of the packed {VecA, VecB, Bias}
// -----------------------------------------------------------------------------
package dense_dot25_calc_pkg;

    localparam int Q_WIDTH = 16;
    localparam int Q_FRAC  = 8;
    localparam int Q_N_TAP = 25;

    localparam logic [Q_WIDTH-1:0] Q_SAT_MAX = 16'h7FFF;
    localparam logic [Q_WIDTH-1:0] Q_SAT_MIN = 16'h8000;

    // Bus order from MSB down: VecA, VecB, Bias.
    localparam int BIAS_BASE  = 0;
    localparam int VEC_B_BASE = Q_WIDTH;
    localparam int VEC_A_BASE = Q_WIDTH * (Q_N_TAP + 1);

    localparam int CALC_BUS_W = Q_WIDTH * (2 * Q_N_TAP + 1);

endpackage

// File: rtl/dense_dot25_calc_add5_tree.sv
// -----------------------------------------------------------------------------
// dense_dot25_calc_add5_tree
// Registered signed sum of five terms plus an offset term. The offset lets the
// final stage fold the bias into the same adder level; the partial-sum stage
// ties it to zero. The data register has no reset: it only loads when en=1.
//   clk          : clock, rising edge
//   en           : load enable (stage valid)
//   a0..a4       : signed addends, IN_W bits
//   offset       : signed extra addend, OUT_W bits
//   sum          : registered signed sum, OUT_W bits
// -----------------------------------------------------------------------------
module dense_dot25_calc_add5_tree #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 35
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  a0,
    input  logic signed [IN_W-1:0]  a1,
    input  logic signed [IN_W-1:0]  a2,
    input  logic signed [IN_W-1:0]  a3,
    input  logic signed [IN_W-1:0]  a4,
    input  logic signed [OUT_W-1:0] offset,
    output logic signed [OUT_W-1:0] sum
);

    always_ff @(posedge clk) begin
        if (en) begin
            sum <= OUT_W'(a0) + OUT_W'(a1) + OUT_W'(a2) + OUT_W'(a3)
                 + OUT_W'(a4) + offset;
        end
    end

endmodule

// File: rtl/dense_dot25_calc.sv
// -----------------------------------------------------------------------------
// dense_dot25_calc
// Pipelined Q8.8 25-tap dot product plus bias for the dense layer. One operand
// word may be accepted per cycle; the result appears four edges after the
// capture edge, in order, with no backpressure.
//   clk               : clock, rising edge
//   rst_n             : asynchronous active-low reset (valids and output)
//   calc_en_i         : operand valid, one computation per cycle it is high
//   data_from_layer_i : packed {VecA, VecB, Bias}
//   data_to_layer_o   : Q8.8 result, held while result_valid_o is low
//   result_valid_o    : one-cycle strobe per accepted operand
// -----------------------------------------------------------------------------
module dense_dot25_calc
    import dense_dot25_calc_pkg::*;
#(
    parameter int WIDTH = Q_WIDTH,
    parameter int N_TAP = Q_N_TAP,
    parameter int FRAC  = Q_FRAC,
    parameter int RELU  = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             calc_en_i,
    input  logic [WIDTH*(2*N_TAP+1)-1:0]     data_from_layer_i,
    output logic [WIDTH-1:0]                 data_to_layer_o,
    output logic                             result_valid_o
);

    localparam int PROD_W   = 2 * WIDTH;
    localparam int PSUM_W   = PROD_W + 3;
    localparam int TOTAL_W  = PSUM_W + 2;
    localparam int N_GRP    = 5;
    localparam int GRP_TAPS = N_TAP / N_GRP;

    // Q8.8 limits sign-extended to the accumulator width.
    localparam logic signed [TOTAL_W-1:0] SAT_HI =
        $signed({{(TOTAL_W-WIDTH){1'b0}}, Q_SAT_MAX});
    localparam logic signed [TOTAL_W-1:0] SAT_LO =
        $signed({{(TOTAL_W-WIDTH){1'b1}}, Q_SAT_MIN});

    logic                      vld_p0, vld_p1, vld_p2, vld_p3;

    logic signed [WIDTH-1:0]   a_p0 [N_TAP];
    logic signed [WIDTH-1:0]   b_p0 [N_TAP];
    logic signed [WIDTH-1:0]   bias_p0, bias_p1, bias_p2;
    logic signed [PROD_W-1:0]  prod_p1 [N_TAP];
    logic signed [PSUM_W-1:0]  psum_p2 [N_GRP];
    logic signed [TOTAL_W-1:0] bias_sh_p2;
    logic signed [TOTAL_W-1:0] total_p3;

    // Floor shift back to Q8.8, clamp to the word range, optional ReLU.
    function automatic logic [WIDTH-1:0] sat_relu(input logic signed [TOTAL_W-1:0] total);
        logic signed [TOTAL_W-1:0] sh;
        sh = total >>> FRAC;
        if ((RELU != 0) && sh[TOTAL_W-1]) begin
            return '0;
        end
        if (sh > SAT_HI) begin
            return Q_SAT_MAX;
        end
        if (sh < SAT_LO) begin
            return Q_SAT_MIN;
        end
        return sh[WIDTH-1:0];
    endfunction

    // Valid chain: the only control state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0         <= 1'b0;
            vld_p1         <= 1'b0;
            vld_p2         <= 1'b0;
            vld_p3         <= 1'b0;
            result_valid_o <= 1'b0;
        end else begin
            vld_p0         <= calc_en_i;
            vld_p1         <= vld_p0;
            vld_p2         <= vld_p1;
            vld_p3         <= vld_p2;
            result_valid_o <= vld_p3;
        end
    end

    // ---- Stage 0: operand capture ----
    always_ff @(posedge clk) begin
        if (calc_en_i) begin
            for (int i = 0; i < N_TAP; i++) begin
                a_p0[i] <= $signed(data_from_layer_i[VEC_A_BASE + WIDTH*i +: WIDTH]);
                b_p0[i] <= $signed(data_from_layer_i[VEC_B_BASE + WIDTH*i +: WIDTH]);
            end
            bias_p0 <= $signed(data_from_layer_i[BIAS_BASE +: WIDTH]);
        end
    end

    // ---- Stage 1: Q16.16 products ----
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            for (int i = 0; i < N_TAP; i++) begin
                prod_p1[i] <= PROD_W'(a_p0[i]) * PROD_W'(b_p0[i]);
            end
            bias_p1 <= bias_p0;
        end
    end

    // ---- Stage 2: five partial sums of five taps ----
    for (genvar g = 0; g < N_GRP; g++) begin : g_psum
        dense_dot25_calc_add5_tree #(
            .IN_W  (PROD_W),
            .OUT_W (PSUM_W)
        ) u_psum (
            .clk    (clk),
            .en     (vld_p1),
            .a0     (prod_p1[GRP_TAPS*g + 0]),
            .a1     (prod_p1[GRP_TAPS*g + 1]),
            .a2     (prod_p1[GRP_TAPS*g + 2]),
            .a3     (prod_p1[GRP_TAPS*g + 3]),
            .a4     (prod_p1[GRP_TAPS*g + 4]),
            .offset ('0),
            .sum    (psum_p2[g])
        );
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            bias_p2 <= bias_p1;
        end
    end

    // ---- Stage 3: total of partials plus bias aligned to Q16.16 ----
    assign bias_sh_p2 = TOTAL_W'(bias_p2) <<< FRAC;

    dense_dot25_calc_add5_tree #(
        .IN_W  (PSUM_W),
        .OUT_W (TOTAL_W)
    ) u_total (
        .clk    (clk),
        .en     (vld_p2),
        .a0     (psum_p2[0]),
        .a1     (psum_p2[1]),
        .a2     (psum_p2[2]),
        .a3     (psum_p2[3]),
        .a4     (psum_p2[4]),
        .offset (bias_sh_p2),
        .sum    (total_p3)
    );

    // ---- Stage 4: shift, saturate, ReLU into the output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_to_layer_o <= '0;
        end else if (vld_p3) begin
            data_to_layer_o <= sat_relu(total_p3);
        end
    end

endmodule
